// File: rtl/beu_clmul_seq_if.sv
// Request/response bundle between the executor (master) and the CLMUL sequencer (slave).
interface beu_clmul_seq_if;
  logic        s_req_valid_i;
  logic        s_req_ready_o;
  logic [1:0]  s_mode_i;
  logic [31:0] s_op1_i;
  logic [31:0] s_op2_i;
  logic        s_flush_i;
  logic        s_resp_valid_o;
  logic        s_resp_ready_i;
  logic [31:0] s_result_o;
  logic        s_busy_o;

  modport master (
    output s_req_valid_i, s_mode_i, s_op1_i, s_op2_i, s_flush_i, s_resp_ready_i,
    input  s_req_ready_o, s_resp_valid_o, s_result_o, s_busy_o
  );

  modport slave (
    input  s_req_valid_i, s_mode_i, s_op1_i, s_op2_i, s_flush_i, s_resp_ready_i,
    output s_req_ready_o, s_resp_valid_o, s_result_o, s_busy_o
  );
endinterface

// File: rtl/beu_clmul_seq.sv
// Multi-cycle CLMUL/CLMULH/CLMULR sequencer, BITS_PER_CYCLE multiplier bits per RUN cycle.
// Optional macro BEU_CLMUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module beu_clmul_seq #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic           s_clk_i,
  input  logic           s_reset_i,
  beu_clmul_seq_if.slave bus
);
  localparam int STEPS = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [63:0]      m_r;
  logic [31:0]      q_r;
  logic [63:0]      acc_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic             busy_r;
  logic [31:0]      result_r;

  logic [63:0]      acc_step_s;
  logic [63:0]      m_step_s;
  logic [31:0]      q_step_s;
  logic             last_step_s;

  function automatic logic [31:0] select_result(input logic [63:0] acc, input logic [1:0] mode);
    logic [31:0] res;
    case (mode)
      2'b00:   res = acc[31:0];
      2'b01:   res = acc[63:32];
      2'b10:   res = acc[62:31];
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // One RUN step: fold in partial products for the low bits of q, then advance both shifters.
  always_comb begin
    acc_step_s = acc_r;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (q_r[j]) begin
        acc_step_s = acc_step_s ^ (m_r << j);
      end else begin
        acc_step_s = acc_step_s;
      end
    end
    m_step_s = m_r << BITS_PER_CYCLE;
    q_step_s = q_r >> BITS_PER_CYCLE;
`ifdef BEU_CLMUL_EARLY_EXIT_EN
    last_step_s = (cnt_r == CNT_LAST) || (q_step_s == 32'd0);
`else
    last_step_s = (cnt_r == CNT_LAST);
`endif
  end

  // Sequencer FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_r      <= ST_IDLE;
      m_r          <= 64'd0;
      q_r          <= 32'd0;
      acc_r        <= 64'd0;
      mode_r       <= 2'd0;
      cnt_r        <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      result_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.s_req_valid_i && !bus.s_flush_i) begin
            m_r         <= {32'd0, bus.s_op1_i};
            q_r         <= bus.s_op2_i;
            mode_r      <= bus.s_mode_i;
            acc_r       <= 64'd0;
            cnt_r       <= '0;
            state_r     <= ST_RUN;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.s_flush_i) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            acc_r <= acc_step_s;
            m_r   <= m_step_s;
            q_r   <= q_step_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_step_s) begin
              state_r      <= ST_DONE;
              resp_valid_r <= 1'b1;
              result_r     <= select_result(acc_step_s, mode_r);
            end else begin
              state_r      <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          // Flush and handshake both retire the result; flush simply discards it.
          if (bus.s_flush_i || bus.s_resp_ready_i) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            result_r     <= 32'd0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
          end else begin
            state_r      <= ST_DONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          result_r     <= 32'd0;
          req_ready_r  <= 1'b1;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_req_ready_o  = req_ready_r;
  assign bus.s_resp_valid_o = resp_valid_r;
  assign bus.s_busy_o       = busy_r;
  assign bus.s_result_o     = result_r;
endmodule
